// File: rtl/frame_buffer_writer.sv
// rtl/frame_buffer_writer.sv - stores one RGB frame from a pixel stream into the shared 32-bit pixel SRAM
// Bus outputs float whenever the block is not enabled so other stages can own the SRAM.
module frame_buffer_writer #(
  parameter int FRAME_BASE   = 0,
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240
) (
  input  logic        clk_div_by_two,
  input  logic        reset_n,
  input  logic        enable_frame_write,
  input  logic        pixel_valid,
  input  logic        pixel_sof,
  input  logic [7:0]  pixel_red,
  input  logic [7:0]  pixel_green,
  input  logic [7:0]  pixel_blue,
  output logic        pixel_ready,
  output logic        wren,
  output logic [31:0] data_write,
  output logic [17:0] address,
  output logic        frame_write_done,
  output logic        frame_write_resync
);

  localparam logic [17:0] BASE  = 18'(FRAME_BASE);
  localparam logic [17:0] TOTAL = 18'(FRAME_WIDTH * FRAME_HEIGHT);

  typedef enum logic [2:0] {
    IDLE, WAIT_SOF, CAPTURE, WRITE, RELEASE, DONE
  } state_t;

  state_t      state;
  logic        bus_own;
  logic        wren_q;
  logic [31:0] data_q;
  logic [17:0] addr_q;
  logic [17:0] pixel_count;

  logic        accept;
  logic [31:0] pixel_word;

  assign accept     = pixel_valid & pixel_ready;
  assign pixel_word = {pixel_blue, 8'h00, pixel_green, pixel_red};

  assign wren       = bus_own ? wren_q : 1'bz;
  assign data_write = bus_own ? data_q : {32{1'bz}};
  assign address    = bus_own ? addr_q : {18{1'bz}};

  always_ff @(posedge clk_div_by_two or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      bus_own            <= 1'b0;
      wren_q             <= 1'b0;
      data_q             <= 32'h0;
      addr_q             <= BASE;
      pixel_count        <= 18'h0;
      pixel_ready        <= 1'b0;
      frame_write_done   <= 1'b0;
      frame_write_resync <= 1'b0;
    end else if (!enable_frame_write) begin
      // Dropping enable abandons everything, including a write in flight.
      state              <= IDLE;
      bus_own            <= 1'b0;
      wren_q             <= 1'b0;
      addr_q             <= BASE;
      pixel_count        <= 18'h0;
      pixel_ready        <= 1'b0;
      frame_write_done   <= 1'b0;
      frame_write_resync <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state       <= WAIT_SOF;
          bus_own     <= 1'b1;
          wren_q      <= 1'b0;
          addr_q      <= BASE;
          pixel_ready <= 1'b1;
        end
        WAIT_SOF: begin
          if (accept && pixel_sof) begin
            data_q      <= pixel_word;
            pixel_count <= 18'h0;
            addr_q      <= BASE;
            wren_q      <= 1'b1;
            pixel_ready <= 1'b0;
            state       <= WRITE;
          end
        end
        CAPTURE: begin
          if (accept) begin
            data_q      <= pixel_word;
            wren_q      <= 1'b1;
            pixel_ready <= 1'b0;
            state       <= WRITE;
            // A fresh SOF mid-frame restarts the frame at pixel (0,0).
            if (pixel_sof && pixel_count != 18'h0) begin
              frame_write_resync <= 1'b1;
              pixel_count        <= 18'h0;
              addr_q             <= BASE;
            end else begin
              addr_q <= BASE + pixel_count;
            end
          end
        end
        WRITE: begin
          wren_q      <= 1'b0;
          pixel_count <= pixel_count + 18'h1;
          state       <= RELEASE;
        end
        RELEASE: begin
          if (pixel_count == TOTAL) begin
            frame_write_done <= 1'b1;
            state            <= DONE;
          end else begin
            pixel_ready <= 1'b1;
            state       <= CAPTURE;
          end
        end
        DONE: begin
          wren_q      <= 1'b0;
          pixel_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb/tb_frame_buffer_writer.sv - randomized self-checking bench for frame_buffer_writer
// A small frame keeps whole-frame runs short; expected writes come from a frame-level model.
module tb_frame_buffer_writer;

  localparam int BASE  = 100;
  localparam int W     = 16;
  localparam int H     = 8;
  localparam int TOTAL = W * H;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable_frame_write;
  logic        pixel_valid;
  logic        pixel_sof;
  logic [7:0]  pixel_red;
  logic [7:0]  pixel_green;
  logic [7:0]  pixel_blue;
  logic        pixel_ready;
  wire         wren;
  wire  [31:0] data_write;
  wire  [17:0] address;
  logic        frame_write_done;
  logic        frame_write_resync;

  frame_buffer_writer #(
    .FRAME_BASE  (BASE),
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H)
  ) dut (
    .clk_div_by_two    (clk),
    .reset_n           (reset_n),
    .enable_frame_write(enable_frame_write),
    .pixel_valid       (pixel_valid),
    .pixel_sof         (pixel_sof),
    .pixel_red         (pixel_red),
    .pixel_green       (pixel_green),
    .pixel_blue        (pixel_blue),
    .pixel_ready       (pixel_ready),
    .wren              (wren),
    .data_write        (data_write),
    .address           (address),
    .frame_write_done  (frame_write_done),
    .frame_write_resync(frame_write_resync)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame-level reference: which pixels land where, in accept order.
  typedef struct {
    logic [17:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  bit  m_started;
  int  m_idx;
  bit  m_resync;
  bit  m_done;

  task automatic model_clear();
    m_started = 0;
    m_idx     = 0;
    m_resync  = 0;
    m_done    = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input bit sof, input logic [31:0] word);
    wr_t e;
    if (!m_started && !sof) return;
    if (!m_started) begin
      m_started = 1;
      m_idx     = 0;
    end else if (sof && m_idx != 0) begin
      m_resync = 1;
      m_idx    = 0;
    end
    e.a = 18'(BASE + m_idx);
    e.d = word;
    exp_q.push_back(e);
    m_idx++;
    if (m_idx == TOTAL) m_done = 1;
  endtask

  // Write monitor: every wren pulse must match the next expected write.
  int  wr_cnt    = 0;
  bit  prev_wren = 0;
  wr_t mon_e;

  always @(negedge clk) begin
    if (wren === 1'b1) begin
      wr_cnt++;
      check("wren_single_cycle", {31'b0, prev_wren}, 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_write_addr", {14'b0, address}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", {14'b0, address}, {14'b0, mon_e.a});
        check("write_data", data_write, mon_e.d);
      end
    end
    prev_wren = (wren === 1'b1);
  end

  task automatic check_released(input string tag);
    check(tag, {30'b0, address !== 18'(BASE), wren !== 1'b1}, 32'd3);
  endtask

  // Called just after a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit sof, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int n;
    pixel_valid = 1'b1;
    pixel_sof   = sof;
    pixel_red   = r;
    pixel_green = g;
    pixel_blue  = b;
    n = 0;
    while (pixel_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      check("ready_timeout", {31'b0, pixel_ready}, 32'd1);
      pixel_valid = 1'b0;
      return;
    end
    model_accept(sof, {b, 8'h00, g, r});
    @(negedge clk);
    pixel_valid = 1'b0;
    pixel_sof   = 1'b0;
  endtask

  task automatic send_random(input bit sof);
    send(sof, 8'($urandom), 8'($urandom), 8'($urandom));
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (frame_write_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, frame_write_done}, 32'd1);
  endtask

  task automatic disable_and_reenable(input string tag);
    enable_frame_write = 1'b0;
    @(negedge clk);
    check({tag, "_done"}, {31'b0, frame_write_done}, 32'd0);
    check({tag, "_resync"}, {31'b0, frame_write_resync}, 32'd0);
    check({tag, "_ready"}, {31'b0, pixel_ready}, 32'd0);
    check_released({tag, "_bus"});
    model_clear();
    enable_frame_write = 1'b1;
    @(negedge clk);
    check({tag, "_wait_sof_ready"}, {31'b0, pixel_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n            = 1'b0;
    enable_frame_write = 1'b0;
    pixel_valid        = 1'b0;
    pixel_sof          = 1'b0;
    pixel_red          = 8'h0;
    pixel_green        = 8'h0;
    pixel_blue         = 8'h0;
    model_clear();
    #23;
    check("reset_ready", {31'b0, pixel_ready}, 32'd0);
    check("reset_done", {31'b0, frame_write_done}, 32'd0);
    check("reset_resync", {31'b0, frame_write_resync}, 32'd0);
    check_released("reset_bus");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'b0, pixel_ready}, 32'd0);
    check_released("idle_bus");

    // Frame A: leading non-SOF pixels are discarded, then a full frame.
    enable_frame_write = 1'b1;
    @(negedge clk);
    check("enable_ready", {31'b0, pixel_ready}, 32'd1);
    check("enable_addr", {14'b0, address}, BASE);
    wr_cnt = 0;
    for (int i = 0; i < 5; i++) send_random(1'b0);
    check("pre_sof_no_writes", 32'(wr_cnt), 32'd0);
    for (int i = 0; i < TOTAL; i++) begin
      if (i == W + 1) begin
        send(1'b0, 8'h12, 8'h34, 8'h56);
        check("xy11_wren", {31'b0, wren === 1'b1}, 32'd1);
        check("xy11_addr", {14'b0, address}, BASE + W + 1);
        check("xy11_data", data_write, 32'h5600_3412);
      end else begin
        send_random(i == 0);
      end
    end
    wait_done("frame_a_done");
    check("frame_a_writes", 32'(wr_cnt), 32'(TOTAL));
    check("frame_a_resync", {31'b0, frame_write_resync}, {31'b0, m_resync});
    check("done_ready", {31'b0, pixel_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("done_holds", {31'b0, frame_write_done}, 32'd1);
    disable_and_reenable("after_a");

    // Frame B: SOF reasserted mid-frame restarts the count.
    wr_cnt = 0;
    for (int i = 0; i < 40 + TOTAL; i++) send_random(i == 0 || i == 40);
    wait_done("frame_b_done");
    check("frame_b_resync", {31'b0, frame_write_resync}, {31'b0, m_resync});
    check("frame_b_writes", 32'(wr_cnt), 32'(40 + TOTAL));
    disable_and_reenable("after_b");

    // Enable dropped while the DUT sits in WRITE.
    for (int i = 0; i < 31; i++) send_random(i == 0);
    send(1'b0, 8'hA5, 8'h5A, 8'hC3);
    disable_and_reenable("drop_in_write");
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-frame, between clock edges.
    for (int i = 0; i < 20; i++) send_random(i == 0);
    send(1'b0, 8'h01, 8'h02, 8'h03);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_ready", {31'b0, pixel_ready}, 32'd0);
    check("async_rst_done", {31'b0, frame_write_done}, 32'd0);
    check_released("async_rst_bus");
    model_clear();
    @(negedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    check("post_rst_idle_ready", {31'b0, pixel_ready}, 32'd0);
    check_released("post_rst_idle_bus");
    @(negedge clk);
    check("post_rst_wait_sof_ready", {31'b0, pixel_ready}, 32'd1);

    // Frame E: clean full frame after reset.
    wr_cnt = 0;
    for (int i = 0; i < 3; i++) send_random(1'b0);
    for (int i = 0; i < TOTAL; i++) send_random(i == 0);
    wait_done("frame_e_done");
    check("frame_e_writes", 32'(wr_cnt), 32'(TOTAL));
    check("frame_e_resync", {31'b0, frame_write_resync}, 32'd0);
    repeat (2) @(negedge clk);
    check("no_pending_writes", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
